// File: rtl/pc_update_unit_if.sv
// Bus bundle between the control path and the PC update unit.
// The control side (master) drives branch/jump requests and candidate
// targets; the PC unit (slave) returns the program counter state.
interface pc_update_unit_if #(
  parameter int WIDTH = 32
);

  // Control requests and ALU flags
  logic             Zero;
  logic             Neg;
  logic             PCWrite;
  logic             PCWriteCond;
  logic [2:0]       BranchType;
  logic [1:0]       PCSource;

  // Candidate next-PC values
  logic [WIDTH-1:0] seq_pc;
  logic [WIDTH-1:0] branch_target;
  logic [WIDTH-1:0] jump_target;
  logic [WIDTH-1:0] reg_target;

  // Pipeline control
  logic             stall;
  logic             exception;

  // PC unit results
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] epc;
  logic             pc_we;
  logic             branch_taken;
  logic             addr_fault;
  logic             slot_pending;

  modport master (
    output Zero, Neg, PCWrite, PCWriteCond, BranchType, PCSource,
    output seq_pc, branch_target, jump_target, reg_target,
    output stall, exception,
    input  pc, epc, pc_we, branch_taken, addr_fault, slot_pending
  );

  modport slave (
    input  Zero, Neg, PCWrite, PCWriteCond, BranchType, PCSource,
    input  seq_pc, branch_target, jump_target, reg_target,
    input  stall, exception,
    output pc, epc, pc_we, branch_taken, addr_fault, slot_pending
  );

endinterface

// File: rtl/pc_update_unit.sv
// Program counter update unit.
// Evaluates the branch condition, selects the next PC, traps misaligned
// targets and external exceptions to EXC_VECTOR, and optionally defers
// redirects by one instruction (branch delay slot) using a two-state FSM.
module pc_update_unit #(
  parameter int               WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter logic [WIDTH-1:0] EXC_VECTOR   = WIDTH'(32'h80),
  parameter int               DELAY_SLOT   = 0
) (
  input logic              clk,
  input logic              reset,
  pc_update_unit_if.slave  bus
);

  localparam bit SLOT_MODE = (DELAY_SLOT != 0);

  typedef enum logic {
    IDLE = 1'b0,
    SLOT = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] epc_q, epc_d;
  logic [WIDTH-1:0] saved_q, saved_d;
  logic             addr_fault_q, addr_fault_d;

  logic             cond;
  logic             branch_taken;
  logic             pc_we;
  logic             redirect;
  logic             in_slot;
  logic             misaligned;
  logic [WIDTH-1:0] next_pc;

  logic             take_exc;
  logic             take_fault;
  logic             take_write;

  // Branch condition selected by BranchType from the ALU flags
  always_comb begin
    cond = 1'b0;
    unique case (bus.BranchType)
      3'b000:  cond = bus.Zero;
      3'b001:  cond = !bus.Zero;
      3'b010:  cond = bus.Neg;
      3'b011:  cond = !bus.Neg;
      3'b100:  cond = bus.Neg | bus.Zero;
      3'b101:  cond = !bus.Neg & !bus.Zero;
      default: cond = 1'b0;
    endcase
  end

  // Candidate mux and effective write enable; both enables are forced low in reset
  always_comb begin
    next_pc = bus.seq_pc;
    unique case (bus.PCSource)
      2'b00:   next_pc = bus.seq_pc;
      2'b01:   next_pc = bus.branch_target;
      2'b10:   next_pc = bus.jump_target;
      default: next_pc = bus.reg_target;
    endcase
    branch_taken = cond & bus.PCWriteCond & !reset;
    pc_we        = (branch_taken | bus.PCWrite) & !bus.stall & !reset;
    redirect     = pc_we & (bus.PCSource != 2'b00);
    in_slot      = SLOT_MODE && (state_q == SLOT);
    // While a redirect is pending the candidates are not used, so their
    // alignment cannot raise a fault.
    misaligned   = pc_we & !in_slot & (next_pc[1:0] != 2'b00);
  end

  // Resolve which single action this edge performs: exception beats stall beats fault beats write
  always_comb begin
    take_exc   = bus.exception;
    take_fault = !bus.exception & !bus.stall & misaligned;
    take_write = !bus.exception & !bus.stall & !misaligned & pc_we;
  end

  // State register for the delay-slot FSM
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: a redirect from IDLE opens the slot, any write in SLOT closes it
  always_comb begin
    state_d = state_q;
    if (!SLOT_MODE) begin
      state_d = IDLE;
    end else if (take_exc || take_fault) begin
      state_d = IDLE;
    end else if (take_write) begin
      if (in_slot) begin
        state_d = IDLE;
      end else if (redirect) begin
        state_d = SLOT;
      end else begin
        state_d = IDLE;
      end
    end
  end

  // Datapath next values for pc, epc, saved target and fault pulse
  always_comb begin
    pc_d         = pc_q;
    epc_d        = epc_q;
    saved_d      = saved_q;
    addr_fault_d = 1'b0;
    if (take_exc) begin
      pc_d    = EXC_VECTOR;
      epc_d   = pc_q;
      saved_d = '0;
    end else if (take_fault) begin
      pc_d         = EXC_VECTOR;
      epc_d        = pc_q;
      addr_fault_d = 1'b1;
    end else if (take_write) begin
      if (!SLOT_MODE) begin
        pc_d = next_pc;
      end else if (in_slot) begin
        pc_d = saved_q;
      end else if (redirect) begin
        saved_d = next_pc;
        pc_d    = bus.seq_pc;
      end else begin
        pc_d = bus.seq_pc;
      end
    end
  end

  // Datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q         <= RESET_VECTOR;
      epc_q        <= '0;
      saved_q      <= '0;
      addr_fault_q <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      epc_q        <= epc_d;
      saved_q      <= saved_d;
      addr_fault_q <= addr_fault_d;
    end
  end

  // Output logic: registered state plus the two combinational enables
  always_comb begin
    bus.pc           = pc_q;
    bus.epc          = epc_q;
    bus.addr_fault   = addr_fault_q;
    bus.slot_pending = (state_q == SLOT);
    bus.pc_we        = pc_we;
    bus.branch_taken = branch_taken;
  end

endmodule
